board_ctrl: RTL and testbench

BOARD_CTRL -- requirements
Module: board_ctrl

---
 rtl/board_ctrl_if.sv | 29 ++
 rtl/board_ctrl.sv | 97 +++++++++
 tb/tb_board_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/board_ctrl_if.sv
// board_ctrl_if: request/response bundle between a game front end and board_ctrl.
//   new_game, move_valid, move_row, move_col, who_won  : front end -> board_ctrl
//   board_state, current_player, move_ack, move_err,
//   busy, game_over, winner, moves_made                 : board_ctrl -> front end
interface board_ctrl_if;
    logic        new_game;
    logic        move_valid;
    logic [1:0]  move_row;
    logic [1:0]  move_col;
    logic [2:0]  who_won;
    logic [17:0] board_state;
    logic        current_player;
    logic        move_ack;
    logic        move_err;
    logic        busy;
    logic        game_over;
    logic [1:0]  winner;
    logic [3:0]  moves_made;

    modport slave (
        input  new_game, move_valid, move_row, move_col, who_won,
        output board_state, current_player, move_ack, move_err, busy, game_over, winner, moves_made
    );

    modport master (
        output new_game, move_valid, move_row, move_col, who_won,
        input  board_state, current_player, move_ack, move_err, busy, game_over, winner, moves_made
    );
endinterface

// File: rtl/board_ctrl.sv
// board_ctrl: tic-tac-toe board keeper; validates moves, waits CHECK_WAIT cycles for
// the external win checker, then advances the turn or ends the game.
//   clk, rst : clock and synchronous active-high reset
//   bus      : board_ctrl_if.slave carrying move requests, checker result and all status
module board_ctrl #(
    parameter int unsigned CHECK_WAIT = 2
) (
    input logic         clk,
    input logic         rst,
    board_ctrl_if.slave bus
);
    typedef enum logic [1:0] {WAIT_MOVE, CHECK, OVER} state_t;
    localparam logic [17:0] EMPTY = 18'h2AAAA;

    state_t      state_q;
    logic [17:0] board_q;
    logic        player_q;
    logic        ack_q;
    logic        err_q;
    logic        busy_q;
    logic        over_q;
    logic [1:0]  winner_q;
    logic [3:0]  moves_q;
    logic [3:0]  cnt_q;
    logic [4:0]  pos_d;
    logic [17:0] sel_d;
    logic        legal_d;

    // Bit offset of the addressed cell; out-of-range rows/columns are rejected before use.
    always_comb begin
        pos_d   = 5'(bus.move_row) * 5'd6 + 5'(bus.move_col) * 5'd2;
        sel_d   = board_q >> pos_d;
        legal_d = (bus.move_row < 2'd3) && (bus.move_col < 2'd3) && (sel_d[1:0] == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst || bus.new_game) begin
            state_q  <= WAIT_MOVE;
            board_q  <= EMPTY;
            player_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= 2'd3;
            moves_q  <= 4'd0;
            cnt_q    <= 4'd0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                WAIT_MOVE: begin
                    if (bus.move_valid && legal_d) begin
                        board_q <= (board_q & ~(18'h3 << pos_d)) | (18'(player_q) << pos_d);
                        moves_q <= moves_q + 4'd1;
                        ack_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= 4'(CHECK_WAIT);
                        state_q <= CHECK;
                    end else if (bus.move_valid) begin
                        err_q <= 1'b1;
                    end
                end
                CHECK: begin
                    cnt_q <= cnt_q - 4'd1;
                    // Last wait cycle: the checker result is taken now.
                    if (cnt_q == 4'd1) begin
                        busy_q <= 1'b0;
                        if (bus.who_won < 3'd2) begin
                            winner_q <= bus.who_won[1:0];
                            over_q   <= 1'b1;
                            state_q  <= OVER;
                        end else if (bus.who_won == 3'd2 || moves_q == 4'd9) begin
                            winner_q <= 2'd2;
                            over_q   <= 1'b1;
                            state_q  <= OVER;
                        end else begin
                            player_q <= ~player_q;
                            state_q  <= WAIT_MOVE;
                        end
                    end
                end
                OVER: err_q <= bus.move_valid;
                default: state_q <= WAIT_MOVE;
            endcase
        end
    end

    assign bus.board_state    = board_q;
    assign bus.current_player = player_q;
    assign bus.move_ack       = ack_q;
    assign bus.move_err       = err_q;
    assign bus.busy           = busy_q;
    assign bus.game_over      = over_q;
    assign bus.winner         = winner_q;
    assign bus.moves_made     = moves_q;
endmodule

// File: tb/tb_board_ctrl.sv
// tb_board_ctrl: directed scoreboard bench for board_ctrl against a small game model.
module tb_board_ctrl;
    localparam int CW = 3;

    typedef struct packed {
        logic ack;
        logic err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [17:0] m_board;
    logic        m_player;
    logic [3:0]  m_moves;
    logic [1:0]  m_winner;
    logic        m_over;
    logic        m_busy;

    board_ctrl_if bus();

    board_ctrl #(.CHECK_WAIT(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status();
        chk("board", 32'(bus.board_state), 32'(m_board));
        chk("player", 32'(bus.current_player), 32'(m_player));
        chk("moves", 32'(bus.moves_made), 32'(m_moves));
        chk("winner", 32'(bus.winner), 32'(m_winner));
        chk("game_over", 32'(bus.game_over), 32'(m_over));
        chk("busy", 32'(bus.busy), 32'(m_busy));
    endtask

    task automatic pop_resp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_ack"}, 32'(bus.move_ack), 32'(e.ack));
            chk({tag, "_err"}, 32'(bus.move_err), 32'(e.err));
        end
    endtask

    // use_rst=1 pulses rst; otherwise new_game with a coincident legal move_valid that must be dropped.
    task automatic do_clear(input bit use_rst);
        if (use_rst) rst = 1'b1;
        else begin
            bus.new_game   = 1'b1;
            bus.move_valid = 1'b1;
            bus.move_row   = 2'd2;
            bus.move_col   = 2'd2;
        end
        sb.push_back('{ack: 1'b0, err: 1'b0});
        @(negedge clk);
        rst = 1'b0;
        bus.new_game   = 1'b0;
        bus.move_valid = 1'b0;
        m_board  = 18'h2AAAA;
        m_player = 1'b0;
        m_moves  = 4'd0;
        m_winner = 2'd3;
        m_over   = 1'b0;
        m_busy   = 1'b0;
        pop_resp(use_rst ? "rst" : "new_game");
        chk_status();
    endtask

    task automatic do_move(input logic [1:0] r, input logic [1:0] c);
        int   p;
        logic legal;
        p = int'(r) * 6 + int'(c) * 2;
        legal = 1'b0;
        if (!m_busy && !m_over && r < 2'd3 && c < 2'd3) legal = (m_board[p +: 2] == 2'd2);
        sb.push_back('{ack: legal, err: !m_busy && !legal});
        bus.move_row   = r;
        bus.move_col   = c;
        bus.move_valid = 1'b1;
        @(negedge clk);
        bus.move_valid = 1'b0;
        if (legal) begin
            m_board[p +: 2] = {1'b0, m_player};
            m_moves = m_moves + 4'd1;
            m_busy  = 1'b1;
        end
        pop_resp("move");
        chk("move_board", 32'(bus.board_state), 32'(m_board));
        chk("move_player", 32'(bus.current_player), 32'(m_player));
        chk("move_moves", 32'(bus.moves_made), 32'(m_moves));
    endtask

    // Drains the CHECK wait (spent cycles already consumed) with the checker showing ww.
    task automatic wait_check(input logic [2:0] ww, input int spent);
        int n;
        n = 0;
        bus.who_won = ww;
        while (bus.busy && n < 40) begin
            n++;
            @(negedge clk);
            chk("check_no_pulse", 32'({bus.move_ack, bus.move_err}), 32'd0);
        end
        chk("busy_cycles", 32'(n), 32'(CW - spent));
        if (ww < 3'd2) begin
            m_winner = ww[1:0];
            m_over   = 1'b1;
        end else if (ww == 3'd2 || m_moves == 4'd9) begin
            m_winner = 2'd2;
            m_over   = 1'b1;
        end else m_player = ~m_player;
        m_busy = 1'b0;
        chk_status();
        bus.who_won = 3'd3;
    endtask

    initial begin
        bus.new_game   = 1'b0;
        bus.move_valid = 1'b0;
        bus.move_row   = 2'd0;
        bus.move_col   = 2'd0;
        bus.who_won    = 3'd3;
        @(negedge clk);
        do_clear(1'b1);
        chk("reset_board_const", 32'(bus.board_state), 32'h2AAAA);

        do_move(2'd1, 2'd1);
        chk("center_bits", 32'(bus.board_state[9:8]), 32'd0);
        wait_check(3'd3, 0);

        do_move(2'd1, 2'd1);
        do_move(2'd3, 2'd0);
        do_move(2'd0, 2'd3);

        do_clear(1'b0);
        do_move(2'd0, 2'd0); wait_check(3'd3, 0);
        do_move(2'd1, 2'd0); wait_check(3'd3, 0);
        do_move(2'd0, 2'd1); wait_check(3'd3, 0);
        do_move(2'd1, 2'd1); wait_check(3'd3, 0);
        do_move(2'd0, 2'd2); wait_check(3'd0, 0);
        do_move(2'd2, 2'd2);
        chk("err_single_cycle", 32'(bus.move_err), 32'd1);
        @(negedge clk);
        chk("err_clears", 32'(bus.move_err), 32'd0);

        do_clear(1'b0);
        do_move(2'd0, 2'd0);
        do_move(2'd0, 2'd1);
        wait_check(3'd3, 1);
        do_move(2'd0, 2'd1); wait_check(3'd3, 0);
        do_move(2'd0, 2'd2); wait_check(3'd3, 0);
        do_move(2'd1, 2'd1); wait_check(3'd3, 0);
        do_move(2'd1, 2'd0); wait_check(3'd5, 0);
        do_move(2'd1, 2'd2); wait_check(3'd3, 0);
        do_move(2'd2, 2'd1); wait_check(3'd3, 0);
        do_move(2'd2, 2'd0); wait_check(3'd3, 0);
        do_move(2'd2, 2'd2); wait_check(3'd7, 0);
        chk("full_moves", 32'(bus.moves_made), 32'd9);
        chk("full_winner", 32'(bus.winner), 32'd2);

        do_clear(1'b0);
        do_move(2'd2, 2'd0); wait_check(3'd2, 0);

        do_clear(1'b0);
        do_move(2'd0, 2'd0); wait_check(3'd3, 0);
        do_move(2'd0, 2'd1); wait_check(3'd3, 0);
        do_move(2'd0, 2'd2); wait_check(3'd3, 0);
        do_move(2'd1, 2'd0); wait_check(3'd3, 0);
        do_move(2'd1, 2'd1);
        do_clear(1'b1);
        do_move(2'd1, 2'd1);
        wait_check(3'd3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
